// File: rtl/sd_pkg.sv
// sd_pkg: shared constants and types for the SPI-mode SD card init sequencer.
//   - SD command indices used during initialization
//   - R1 response codes
//   - err_t  : failure cause reported on err_code
//   - state_t: sequencer FSM states
//   - step_t : position in the initialization command table
package sd_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_READY   = 8'h00;
  localparam logic [7:0] R1_ILLEGAL = 8'h05;
  localparam logic [7:0] R1_TIMEOUT = 8'hFF;

  localparam logic [31:0] ARG_NONE       = 32'h0000_0000;
  localparam logic [31:0] ARG_CMD8       = 32'h0000_01AA;  // 2.7-3.6V, check pattern 0xAA
  localparam logic [31:0] ARG_ACMD41_HCS = 32'h4000_0000;  // host supports high capacity
  localparam logic [31:0] ARG_BLOCKLEN   = 32'd512;
  localparam logic [11:0] CMD8_ECHO      = 12'h1AA;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_CMD0       = 3'd1,
    ERR_CMD8       = 3'd2,
    ERR_ACMD41_R1  = 3'd3,
    ERR_ACMD41_MAX = 3'd4,
    ERR_CMD58      = 3'd5,
    ERR_CMD16      = 3'd6,
    ERR_TIMEOUT    = 3'd7
  } err_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_POWERUP = 4'd1,
    S_ISSUE   = 4'd2,
    S_WAIT    = 4'd3,
    S_RELEASE = 4'd4,
    S_CHECK   = 4'd5,
    S_GAP     = 4'd6,
    S_DONE    = 4'd7,
    S_FAIL    = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    STEP_CMD0  = 3'd0,
    STEP_CMD8  = 3'd1,
    STEP_CMD55 = 3'd2,
    STEP_CMD41 = 3'd3,
    STEP_CMD58 = 3'd4,
    STEP_CMD16 = 3'd5
  } step_t;

endpackage

// File: rtl/sd_init_step_rom.sv
// sd_init_step_rom: combinational initialization command table.
// Ports:
//   step      in   current step
//   v2        in   card answered CMD8 (physical layer v2.00+)
//   sdhc      in   card is block-addressed (CCS), as known for this step
//   index     out  command index to issue for step
//   argument  out  command argument for step (ACMD41 HCS depends on v2)
//   next_step out  step following a passing response
//   last      out  a passing response on this step completes initialization
module sd_init_step_rom
  import sd_pkg::*;
(
  input  step_t       step,
  input  logic        v2,
  input  logic        sdhc,
  output logic [5:0]  index,
  output logic [31:0] argument,
  output step_t       next_step,
  output logic        last
);

  always_comb begin
    index     = CMD0;
    argument  = ARG_NONE;
    next_step = STEP_CMD0;
    last      = 1'b0;
    case (step)
      STEP_CMD0: begin
        index     = CMD0;
        next_step = STEP_CMD8;
      end
      STEP_CMD8: begin
        index     = CMD8;
        argument  = ARG_CMD8;
        next_step = STEP_CMD55;
      end
      STEP_CMD55: begin
        index     = CMD55;
        next_step = STEP_CMD41;
      end
      STEP_CMD41: begin
        index     = CMD41;
        argument  = v2 ? ARG_ACMD41_HCS : ARG_NONE;
        // v1 cards have no OCR CCS bit worth reading; go straight to block length
        next_step = v2 ? STEP_CMD58 : STEP_CMD16;
      end
      STEP_CMD58: begin
        index     = CMD58;
        next_step = STEP_CMD16;
        // block-addressed cards have a fixed 512-byte block; skip CMD16
        last      = sdhc;
      end
      STEP_CMD16: begin
        index     = CMD16;
        argument  = ARG_BLOCKLEN;
        last      = 1'b1;
      end
      default: begin
        index     = CMD0;
        next_step = STEP_CMD0;
      end
    endcase
  end

endmodule

// File: rtl/sd_init_seq.sv
// sd_init_seq: power-up and initialization sequencer for an SPI-mode SD card.
// Issues CMD0, CMD8, CMD55/ACMD41 (polled), CMD58 and CMD16 through the
// command/response unit and reports ready / card type / coded failure.
// Optional build macro: SD_INIT_CMD0_RETRY_EN -- a CMD0 response timeout
// returns to POWERUP up to 3 extra times before failing with err_code 7.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             level; rising edge begins initialization
//   busy/done/error   status levels
//   err_code[2:0]     failure cause (valid while error)
//   card_sdhc         card is block-addressed (valid while done)
//   cs_n              card chip select
//   cmd_index[5:0], cmd_argument[31:0], cmd_start -> command/response unit
//   cmd_finish, cmd_response[39:0]                <- command/response unit
module sd_init_seq
  import sd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 1000,
  parameter int unsigned ACMD41_MAX     = 1023,
  parameter int unsigned RETRY_GAP      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        card_sdhc,
  output logic        cs_n,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_argument,
  output logic        cmd_start,
  input  logic        cmd_finish,
  input  logic [39:0] cmd_response
);

  localparam int unsigned CNT_MAX = (POWERUP_CYCLES > RETRY_GAP) ? POWERUP_CYCLES : RETRY_GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t           state;
  step_t            step;
  logic             start_q;
  logic             start_edge;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       attempts;
  logic             v2;
  logic             sdhc_q;
  err_t             err_q;
  logic [7:0]       r1_q;
  logic [11:0]      echo_q;
  logic             ccs_q;
`ifdef SD_INIT_CMD0_RETRY_EN
  logic [1:0]       cmd0_retries;
`endif

  logic [5:0]       rom_index;
  logic [31:0]      rom_argument;
  step_t            rom_next;
  logic             rom_last;
  logic             rom_sdhc;

  logic             pu_last;
  logic             gap_last;
  logic             chk_pass;
  logic             chk_gap;
  logic             chk_retry;
  logic             chk_fail;
  logic             chk_v2;
  err_t             chk_err;

  logic             unused_resp_bits;
  assign unused_resp_bits = ^{cmd_response[31], cmd_response[29:12]};

  assign start_edge = start & ~start_q;

  // CCS is only meaningful while evaluating CMD58; elsewhere use the stored value
  assign rom_sdhc = (step == STEP_CMD58) ? ccs_q : sdhc_q;

  sd_init_step_rom u_rom (
    .step      (step),
    .v2        (v2),
    .sdhc      (rom_sdhc),
    .index     (rom_index),
    .argument  (rom_argument),
    .next_step (rom_next),
    .last      (rom_last)
  );

  assign pu_last  = (POWERUP_CYCLES <= 1) || (cnt == CNT_W'(POWERUP_CYCLES - 1));
  assign gap_last = (RETRY_GAP <= 1)      || (cnt == CNT_W'(RETRY_GAP - 1));

  // Response evaluation for the current step; a timeout outranks every step rule.
  always_comb begin
    chk_pass  = 1'b0;
    chk_gap   = 1'b0;
    chk_retry = 1'b0;
    chk_fail  = 1'b0;
    chk_err   = ERR_NONE;
    chk_v2    = v2;
    if (r1_q == R1_TIMEOUT) begin
      chk_fail = 1'b1;
      chk_err  = ERR_TIMEOUT;
`ifdef SD_INIT_CMD0_RETRY_EN
      if (step == STEP_CMD0 && cmd0_retries != 2'd3) begin
        chk_fail  = 1'b0;
        chk_retry = 1'b1;
      end
`endif
    end else begin
      case (step)
        STEP_CMD0: begin
          if (r1_q == R1_IDLE) chk_pass = 1'b1;
          else begin chk_fail = 1'b1; chk_err = ERR_CMD0; end
        end
        STEP_CMD8: begin
          if (r1_q == R1_IDLE && echo_q == CMD8_ECHO) begin
            chk_pass = 1'b1;
            chk_v2   = 1'b1;
          end else if (r1_q == R1_ILLEGAL) begin
            chk_pass = 1'b1;
            chk_v2   = 1'b0;
          end else begin
            chk_fail = 1'b1;
            chk_err  = ERR_CMD8;
          end
        end
        STEP_CMD55: begin
          if (r1_q == R1_READY || r1_q == R1_IDLE) chk_pass = 1'b1;
          else begin chk_fail = 1'b1; chk_err = ERR_ACMD41_R1; end
        end
        STEP_CMD41: begin
          if (r1_q == R1_READY) chk_pass = 1'b1;
          else if (r1_q == R1_IDLE) begin
            if ((32'(attempts) + 32'd1) >= ACMD41_MAX) begin
              chk_fail = 1'b1;
              chk_err  = ERR_ACMD41_MAX;
            end else begin
              chk_gap = 1'b1;
            end
          end else begin
            chk_fail = 1'b1;
            chk_err  = ERR_ACMD41_R1;
          end
        end
        STEP_CMD58: begin
          if (r1_q == R1_READY) chk_pass = 1'b1;
          else begin chk_fail = 1'b1; chk_err = ERR_CMD58; end
        end
        STEP_CMD16: begin
          if (r1_q == R1_READY) chk_pass = 1'b1;
          else begin chk_fail = 1'b1; chk_err = ERR_CMD16; end
        end
        default: begin
          chk_fail = 1'b1;
          chk_err  = ERR_CMD0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      step         <= STEP_CMD0;
      start_q      <= 1'b0;
      cnt          <= '0;
      attempts     <= '0;
      v2           <= 1'b0;
      sdhc_q       <= 1'b0;
      err_q        <= ERR_NONE;
      r1_q         <= '0;
      echo_q       <= '0;
      ccs_q        <= 1'b0;
      cmd_start    <= 1'b0;
      cmd_index    <= '0;
      cmd_argument <= '0;
`ifdef SD_INIT_CMD0_RETRY_EN
      cmd0_retries <= '0;
`endif
    end else begin
      start_q <= start;
      case (state)
        // DONE and FAIL hold their status and behave like IDLE for a new start
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_edge) begin
            state    <= S_POWERUP;
            step     <= STEP_CMD0;
            cnt      <= '0;
            attempts <= '0;
            v2       <= 1'b0;
            sdhc_q   <= 1'b0;
            err_q    <= ERR_NONE;
`ifdef SD_INIT_CMD0_RETRY_EN
            cmd0_retries <= '0;
`endif
          end
        end
        S_POWERUP: begin
          if (pu_last) begin
            state <= S_ISSUE;
            step  <= STEP_CMD0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          cmd_index    <= rom_index;
          cmd_argument <= rom_argument;
          cmd_start    <= 1'b1;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (cmd_finish) begin
            r1_q      <= cmd_response[39:32];
            echo_q    <= cmd_response[11:0];
            ccs_q     <= cmd_response[30];
            cmd_start <= 1'b0;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!cmd_finish) state <= S_CHECK;
        end
        S_CHECK: begin
          v2 <= chk_v2;
          if (chk_retry) begin
            state <= S_POWERUP;
            cnt   <= '0;
`ifdef SD_INIT_CMD0_RETRY_EN
            cmd0_retries <= cmd0_retries + 2'd1;
`endif
          end else if (chk_fail) begin
            err_q <= chk_err;
            state <= S_FAIL;
          end else if (chk_gap) begin
            attempts <= attempts + 10'd1;
            cnt      <= '0;
            state    <= S_GAP;
          end else if (chk_pass) begin
            if (step == STEP_CMD58) sdhc_q <= ccs_q;
            if (rom_last) begin
              state <= S_DONE;
            end else begin
              step  <= rom_next;
              state <= S_ISSUE;
            end
          end
        end
        S_GAP: begin
          if (gap_last) begin
            state <= S_ISSUE;
            step  <= STEP_CMD55;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = state inside {S_POWERUP, S_ISSUE, S_WAIT, S_RELEASE, S_CHECK, S_GAP};
  assign done      = (state == S_DONE);
  assign error     = (state == S_FAIL);
  assign cs_n      = state inside {S_IDLE, S_POWERUP, S_FAIL};
  assign err_code  = err_q;
  assign card_sdhc = sdhc_q;

endmodule

// File: tb/tb_sd_init_seq.sv
module tb_sd_init_seq;

  localparam int unsigned PU_CYC = 20;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, error, card_sdhc, cs_n, cmd_start, cmd_finish;
  logic [2:0]  err_code;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic [39:0] cmd_response;

  int unsigned test_cnt = 0;
  int unsigned fail_cnt = 0;

  typedef struct packed { logic [5:0] idx; logic [31:0] arg; } cmd_t;
  cmd_t exp_q[$];

  // card model configuration
  logic [7:0]  cmd0_r1, cmd8_r1, cmd55_r1, cmd58_r1, cmd16_r1;
  logic [31:0] cmd8_payload, ocr;
  int unsigned acmd41_busy, acmd41_seen, cmd0_seen, finish_hold;

  sd_init_seq #(
    .POWERUP_CYCLES (PU_CYC),
    .ACMD41_MAX     (4),
    .RETRY_GAP      (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .card_sdhc    (card_sdhc),
    .cs_n         (cs_n),
    .cmd_index    (cmd_index),
    .cmd_argument (cmd_argument),
    .cmd_start    (cmd_start),
    .cmd_finish   (cmd_finish),
    .cmd_response (cmd_response)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Card / command-unit model with scoreboard on issued commands.
  initial begin : card
    int unsigned phase, delay, hold;
    cmd_t cur, e;
    logic [7:0]  r1;
    logic [31:0] pl;
    cmd_finish = 1'b0;
    cmd_response = '0;
    phase = 0; delay = 0; hold = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      case (phase)
        0: if (cmd_start) begin
          cur.idx = cmd_index;
          cur.arg = cmd_argument;
          test_cnt++;
          if (exp_q.size() == 0) begin
            fail_cnt++;
            $display("FAIL unexpected_cmd: got CMD%0d arg %h, required no command", cur.idx, cur.arg);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              fail_cnt++;
              $display("FAIL cmd_seq: got CMD%0d arg %h, required CMD%0d arg %h", cur.idx, cur.arg, e.idx, e.arg);
            end
          end
          test_cnt++;
          if (cs_n !== 1'b0) begin
            fail_cnt++;
            $display("FAIL cs_n_during_cmd: got %b, required 0", cs_n);
          end
          if (cur.idx == 6'd41) acmd41_seen++;
          if (cur.idx == 6'd0) cmd0_seen++;
          delay = 2;
          phase = 1;
        end
        1: if (!cmd_start) phase = 0;
        else begin
          delay--;
          if (delay == 0) begin
            pl = '0;
            case (cur.idx)
              6'd0:  r1 = cmd0_r1;
              6'd8:  begin r1 = cmd8_r1; pl = cmd8_payload; end
              6'd55: r1 = cmd55_r1;
              6'd41: r1 = (acmd41_seen <= acmd41_busy) ? 8'h01 : 8'h00;
              6'd58: begin r1 = cmd58_r1; pl = ocr; end
              6'd16: r1 = cmd16_r1;
              default: r1 = 8'h04;
            endcase
            if (r1 == 8'hFF) pl = '1;
            cmd_response = {r1, pl};
            cmd_finish = 1'b1;
            phase = 2;
          end
        end
        2: if (!cmd_start) begin
          test_cnt++;
          if (cmd_index !== cur.idx || cmd_argument !== cur.arg) begin
            fail_cnt++;
            $display("FAIL cmd_hold: got CMD%0d arg %h after cmd_start fell, required CMD%0d arg %h",
                     cmd_index, cmd_argument, cur.idx, cur.arg);
          end
          hold = finish_hold;
          phase = 3;
        end
        default: begin
          test_cnt++;
          if (cmd_start) begin
            fail_cnt++;
            $display("FAIL handshake: cmd_start=1 while cmd_finish still 1, required 0");
          end
          if (hold == 0) begin
            cmd_finish = 1'b0;
            phase = 0;
          end else begin
            hold--;
          end
        end
      endcase
    end
  end

  function automatic void push_cmd(input logic [5:0] idx, input logic [31:0] arg);
    cmd_t c;
    c.idx = idx;
    c.arg = arg;
    exp_q.push_back(c);
  endfunction

  task automatic card_default();
    cmd0_r1 = 8'h01; cmd8_r1 = 8'h01; cmd8_payload = 32'h0000_01AA;
    cmd55_r1 = 8'h01; cmd58_r1 = 8'h00; ocr = 32'hC0FF_8000; cmd16_r1 = 8'h00;
    acmd41_busy = 0; acmd41_seen = 0; cmd0_seen = 0; finish_hold = 0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (done || error) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    test_cnt++;
    if ({busy, done, error, err_code, card_sdhc, cs_n, cmd_start, cmd_index, cmd_argument} !==
        {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 6'd0, 32'd0}) begin
      fail_cnt++;
      $display("FAIL reset_state: got busy%b done%b err%b code%0d sdhc%b cs_n%b start%b idx%0d arg%h, required cs_n=1 others 0",
               busy, done, error, err_code, card_sdhc, cs_n, cmd_start, cmd_index, cmd_argument);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sdhc();
    bit to;
    int unsigned n;
    card_default();
    acmd41_busy = 1;
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA);
    repeat (2) begin push_cmd(6'd55, 32'h0); push_cmd(6'd41, 32'h4000_0000); end
    push_cmd(6'd58, 32'h0);
    pulse_start();
    test_cnt++;
    if (cs_n !== 1'b1 || busy !== 1'b1) begin
      fail_cnt++;
      $display("FAIL powerup_state: got cs_n=%b busy=%b, required 1 1", cs_n, busy);
    end
    n = 0;
    while (!cmd_start && n < 200) begin @(negedge clk); n++; end
    test_cnt++;
    if (n < PU_CYC || n > PU_CYC + 4) begin
      fail_cnt++;
      $display("FAIL powerup_len: got %0d cycles to first command, required %0d..%0d", n, PU_CYC, PU_CYC + 4);
    end
    wait_end(to);
    test_cnt++;
    if (to) begin fail_cnt++; $display("FAIL sdhc_timeout: got no done/error, required done"); end
    test_cnt++;
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL sdhc_missing: got %0d commands not issued, required 0", exp_q.size()); end
    test_cnt++;
    if ({done, error, card_sdhc, busy, cs_n, err_code} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      fail_cnt++;
      $display("FAIL sdhc_status: got done%b err%b sdhc%b busy%b cs_n%b code%0d, required 1 0 1 0 0 0",
               done, error, card_sdhc, busy, cs_n, err_code);
    end
    test_cnt++;
    if (acmd41_seen != 2) begin fail_cnt++; $display("FAIL sdhc_acmd41_count: got %0d, required 2", acmd41_seen); end
  endtask

  task automatic test_v1();
    bit to;
    card_default();
    cmd8_r1 = 8'h05; cmd8_payload = 32'h0;
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA); push_cmd(6'd55, 32'h0);
    push_cmd(6'd41, 32'h0); push_cmd(6'd16, 32'd512);
    pulse_start();
    wait_end(to);
    test_cnt++;
    if (to || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL v1_flow: got timeout=%b pending=%0d, required 0 0", to, exp_q.size());
    end
    test_cnt++;
    if ({done, error, card_sdhc, err_code} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      fail_cnt++;
      $display("FAIL v1_status: got done%b err%b sdhc%b code%0d, required 1 0 0 0", done, error, card_sdhc, err_code);
    end
  endtask

  task automatic test_cmd8_echo();
    bit to;
    card_default();
    cmd8_payload = 32'h0000_01AB;
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA);
    pulse_start();
    wait_end(to);
    test_cnt++;
    if (to || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL cmd8_flow: got timeout=%b pending=%0d, required 0 0", to, exp_q.size());
    end
    test_cnt++;
    if ({error, done, err_code, cs_n, busy} !== {1'b1, 1'b0, 3'd2, 1'b1, 1'b0}) begin
      fail_cnt++;
      $display("FAIL cmd8_status: got err%b done%b code%0d cs_n%b busy%b, required 1 0 2 1 0",
               error, done, err_code, cs_n, busy);
    end
  endtask

  task automatic test_acmd41_exhaust();
    bit to;
    card_default();
    acmd41_busy = 1000;
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA);
    repeat (4) begin push_cmd(6'd55, 32'h0); push_cmd(6'd41, 32'h4000_0000); end
    pulse_start();
    wait_end(to);
    test_cnt++;
    if (to || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL acmd41_flow: got timeout=%b pending=%0d, required 0 0", to, exp_q.size());
    end
    test_cnt++;
    if ({error, err_code} !== {1'b1, 3'd4} || acmd41_seen != 4) begin
      fail_cnt++;
      $display("FAIL acmd41_exhaust: got err%b code%0d attempts=%0d, required 1 4 4", error, err_code, acmd41_seen);
    end
  endtask

  task automatic test_r1_errors();
    bit to;
    logic [2:0] exp_code;
    for (int unsigned k = 0; k < 5; k++) begin
      card_default();
      push_cmd(6'd0, 32'h0);
      case (k)
        0: begin cmd0_r1 = 8'h00; exp_code = 3'd1; end
        1: begin cmd55_r1 = 8'h04; exp_code = 3'd3;
                 push_cmd(6'd8, 32'h1AA); push_cmd(6'd55, 32'h0); end
        2: begin cmd58_r1 = 8'h01; exp_code = 3'd5;
                 push_cmd(6'd8, 32'h1AA); push_cmd(6'd55, 32'h0);
                 push_cmd(6'd41, 32'h4000_0000); push_cmd(6'd58, 32'h0); end
        3: begin cmd8_r1 = 8'h05; cmd16_r1 = 8'h01; exp_code = 3'd6;
                 push_cmd(6'd8, 32'h1AA); push_cmd(6'd55, 32'h0);
                 push_cmd(6'd41, 32'h0); push_cmd(6'd16, 32'd512); end
        default: begin ocr = 32'h80FF_8000; exp_code = 3'd0;
                 push_cmd(6'd8, 32'h1AA); push_cmd(6'd55, 32'h0);
                 push_cmd(6'd41, 32'h4000_0000); push_cmd(6'd58, 32'h0);
                 push_cmd(6'd16, 32'd512); end
      endcase
      pulse_start();
      wait_end(to);
      test_cnt++;
      if (to || exp_q.size() != 0 || error !== (exp_code != 3'd0) || err_code !== exp_code ||
          card_sdhc !== 1'b0) begin
        fail_cnt++;
        $display("FAIL r1_case%0d: got timeout=%b pending=%0d err%b code%0d sdhc%b, required 0 0 %b %0d 0",
                 k, to, exp_q.size(), error, err_code, card_sdhc, exp_code != 3'd0, exp_code);
      end
    end
  endtask

  task automatic test_cmd0_timeout();
    bit to;
    int unsigned n_cmd0;
`ifdef SD_INIT_CMD0_RETRY_EN
    n_cmd0 = 4;
`else
    n_cmd0 = 1;
`endif
    card_default();
    cmd0_r1 = 8'hFF;
    repeat (n_cmd0) push_cmd(6'd0, 32'h0);
    pulse_start();
    wait_end(to);
    test_cnt++;
    if (to || exp_q.size() != 0 || cmd0_seen != n_cmd0) begin
      fail_cnt++;
      $display("FAIL cmd0_timeout_flow: got timeout=%b pending=%0d cmd0=%0d, required 0 0 %0d",
               to, exp_q.size(), cmd0_seen, n_cmd0);
    end
    test_cnt++;
    if ({error, err_code, cs_n} !== {1'b1, 3'd7, 1'b1}) begin
      fail_cnt++;
      $display("FAIL cmd0_timeout_status: got err%b code%0d cs_n%b, required 1 7 1", error, err_code, cs_n);
    end
  endtask

  task automatic test_handshake();
    bit to;
    card_default();
    finish_hold = 20;
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA); push_cmd(6'd55, 32'h0);
    push_cmd(6'd41, 32'h4000_0000); push_cmd(6'd58, 32'h0);
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    test_cnt++;
    if (busy !== 1'b1 || cs_n !== 1'b1) begin
      fail_cnt++;
      $display("FAIL start_while_busy: got busy=%b cs_n=%b, required 1 1", busy, cs_n);
    end
    wait_end(to);
    test_cnt++;
    if (to || exp_q.size() != 0 || cmd0_seen != 1 || done !== 1'b1 || card_sdhc !== 1'b1) begin
      fail_cnt++;
      $display("FAIL handshake_flow: got timeout=%b pending=%0d cmd0=%0d done=%b sdhc=%b, required 0 0 1 1 1",
               to, exp_q.size(), cmd0_seen, done, card_sdhc);
    end
  endtask

  task automatic test_reset_in_wait();
    int unsigned n;
    card_default();
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA);
    pulse_start();
    n = 0;
    while (!(cmd_start && cmd_index == 6'd8) && n < 500) begin @(negedge clk); n++; end
    test_cnt++;
    if (n >= 500) begin fail_cnt++; $display("FAIL reset_wait_reach: got no CMD8 in flight, required CMD8"); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_cnt++;
    if ({busy, done, error, err_code, card_sdhc, cs_n, cmd_start, cmd_index, cmd_argument} !==
        {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 6'd0, 32'd0}) begin
      fail_cnt++;
      $display("FAIL reset_in_wait: got busy%b done%b err%b code%0d sdhc%b cs_n%b start%b idx%0d arg%h, required cs_n=1 others 0",
               busy, done, error, err_code, card_sdhc, cs_n, cmd_start, cmd_index, cmd_argument);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    test_cnt++;
    if (busy !== 1'b0 || cmd_start !== 1'b0 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL reset_stays_idle: got busy=%b cmd_start=%b pending=%0d, required 0 0 0",
               busy, cmd_start, exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    card_default();
    test_reset();
    test_sdhc();
    test_v1();
    test_cmd8_echo();
    test_acmd41_exhaust();
    test_r1_errors();
    test_cmd0_timeout();
    test_handshake();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
